// File: rtl/sprite_row_fetcher_if.sv
// Bundle of line-request, ROM and pixel signals between timing, sprite ROM and colour mapper.
// Suffixes are from the fetcher's point of view (slave modport).
interface sprite_row_fetcher_if #(
  parameter int COORD_W = 10,
  parameter int IDX_W   = 4,
  parameter int ADDR_W  = 8
);
  logic               line_start_i;
  logic [COORD_W-1:0] next_y_i;
  logic [COORD_W-1:0] sprite_x_i;
  logic [COORD_W-1:0] sprite_y_i;
  logic               sprite_en_i;
  logic               flash_i;
  logic [ADDR_W-1:0]  rom_addr_o;
  logic [IDX_W-1:0]   rom_q_i;
  logic [COORD_W-1:0] draw_x_i;
  logic               pixel_valid_o;
  logic [IDX_W-1:0]   pixel_idx_o;
  logic               busy_o;

  modport slave (
    input  line_start_i, next_y_i, sprite_x_i, sprite_y_i, sprite_en_i, flash_i,
    input  rom_q_i, draw_x_i,
    output rom_addr_o, pixel_valid_o, pixel_idx_o, busy_o
  );

  modport master (
    output line_start_i, next_y_i, sprite_x_i, sprite_y_i, sprite_en_i, flash_i,
    output rom_q_i, draw_x_i,
    input  rom_addr_o, pixel_valid_o, pixel_idx_o, busy_o
  );
endinterface

// File: rtl/sprite_row_fetcher.sv
// Fetches one sprite row per line_start into a line buffer (one ROM read/cycle, 16 cycles),
// then emits a registered palette index one cycle after draw_x; no backpressure, line_start restarts.
module sprite_row_fetcher #(
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 16,
  parameter int IDX_W    = 4,
  parameter int COORD_W  = 10
) (
  input logic               clk,
  input logic               rst,
  sprite_row_fetcher_if.slave bus
);
  localparam int COL_W = $clog2(SPRITE_W);
  localparam int ROW_W = $clog2(SPRITE_H);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    READY = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               row_valid_q, row_valid_d;
  logic [COORD_W-1:0] latched_x_q, latched_x_d;
  logic               pixel_valid_q, pixel_valid_d;
  logic [IDX_W-1:0]   pixel_idx_q, pixel_idx_d;
  logic [IDX_W-1:0]   buf_q [SPRITE_W];

  logic [COORD_W-1:0] row_diff;
  logic               hit;
  logic [COORD_W:0]   off;
  logic               in_range;
  logic [IDX_W-1:0]   px;

  assign row_diff = bus.next_y_i - bus.sprite_y_i;
  assign hit      = bus.sprite_en_i && (bus.next_y_i >= bus.sprite_y_i)
                    && (row_diff < COORD_W'(SPRITE_H));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      col_q         <= '0;
      row_q         <= '0;
      row_valid_q   <= 1'b0;
      latched_x_q   <= '0;
      pixel_valid_q <= 1'b0;
      pixel_idx_q   <= '0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      row_valid_q   <= row_valid_d;
      latched_x_q   <= latched_x_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_idx_q   <= pixel_idx_d;
    end
  end

  // Buffer is not reset; row_valid_q masks whatever it holds.
  always_ff @(posedge clk) begin
    if (state_q == FETCH && !bus.line_start_i) begin
      buf_q[col_q] <= bus.rom_q_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    row_valid_d = row_valid_q;
    latched_x_d = latched_x_q;
    if (bus.line_start_i) begin
      // A new request always wins, including over a fetch in progress.
      row_valid_d = 1'b0;
      col_d       = '0;
      if (hit) begin
        state_d     = FETCH;
        row_d       = row_diff[ROW_W-1:0];
        latched_x_d = bus.sprite_x_i;
      end else begin
        state_d = READY;
      end
    end else if (state_q == FETCH) begin
      col_d = col_q + 1'b1;
      if (col_q == COL_W'(SPRITE_W - 1)) begin
        state_d     = READY;
        row_valid_d = 1'b1;
      end
    end
  end

  always_comb begin
    bus.rom_addr_o = '0;
    bus.busy_o     = 1'b0;
    if (state_q == FETCH) begin
      bus.rom_addr_o = {row_q, col_q};
      bus.busy_o     = 1'b1;
    end

    // One extra bit keeps sprites near the right edge from wrapping to column 0.
    off      = {1'b0, bus.draw_x_i} - {1'b0, latched_x_q};
    in_range = row_valid_q && (state_q == READY) && (bus.draw_x_i >= latched_x_q)
               && (off < (COORD_W + 1)'(SPRITE_W));
    px       = buf_q[off[COL_W-1:0]];

    pixel_valid_d = 1'b0;
    pixel_idx_d   = '0;
    if (in_range && px != IDX_W'(1)) begin
      pixel_valid_d = 1'b1;
      if (bus.flash_i && px == IDX_W'(0)) begin
        pixel_idx_d = IDX_W'(2);
      end else if (bus.flash_i && px == IDX_W'(2)) begin
        pixel_idx_d = IDX_W'(0);
      end else begin
        pixel_idx_d = px;
      end
    end
  end

  assign bus.pixel_valid_o = pixel_valid_q;
  assign bus.pixel_idx_o   = pixel_idx_q;
endmodule

// File: tb/tb_sprite_row_fetcher.sv
// Bench for sprite_row_fetcher: fetch sequencing, hit/miss, flash swap, right-edge clipping, abort.
module tb_sprite_row_fetcher;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  sprite_row_fetcher_if #(.COORD_W(10), .IDX_W(4), .ADDR_W(8)) sif ();

  sprite_row_fetcher #(
    .SPRITE_W(16), .SPRITE_H(16), .IDX_W(4), .COORD_W(10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synthetic scared-ghost ROM: rows 0-3 hold indices 0..3, later rows differ in the top bits.
  function automatic logic [3:0] rom_val(input logic [3:0] r, input logic [3:0] c);
    logic [3:0] s;
    s = c + {r[2:0], 1'b0} + 4'd3;
    return {r[3:2], s[1:0]};
  endfunction

  assign sif.rom_q_i = rom_val(sif.rom_addr_o[7:4], sif.rom_addr_o[3:0]);

  // Expected {valid, idx} for a pixel at x given sprite left edge sx and fetched row r.
  function automatic logic [4:0] model_px(input logic [3:0] r, input int x, input int sx,
                                          input logic fl);
    int         off;
    logic [3:0] val;
    logic [3:0] oc;
    off = x - sx;
    if (off < 0 || off > 15) return 5'd0;
    oc  = off[3:0];
    val = rom_val(r, oc);
    if (val == 4'd1) return 5'd0;
    if (fl && val == 4'd0) return {1'b1, 4'd2};
    if (fl && val == 4'd2) return {1'b1, 4'd0};
    return {1'b1, val};
  endfunction

  typedef struct {
    int         x;
    logic       fl;
    logic [4:0] exp;
  } vec_t;

  vec_t       tbl [64];
  int         ntbl = 0;
  logic [4:0] sb_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input int x, input logic fl, input logic [4:0] exp);
    tbl[ntbl].x   = x;
    tbl[ntbl].fl  = fl;
    tbl[ntbl].exp = exp;
    ntbl++;
  endtask

  task automatic run_vecs(input string name);
    logic [4:0] got;
    logic [4:0] want;
    for (int i = 0; i < ntbl; i++) begin
      sif.draw_x_i = 10'(tbl[i].x);
      sif.flash_i  = tbl[i].fl;
      sb_q.push_back(tbl[i].exp);
      step();
      got  = {sif.pixel_valid_o, sif.pixel_idx_o};
      want = sb_q.pop_front();
      chk($sformatf("%s x=%0d fl=%0d", name, tbl[i].x, tbl[i].fl), 32'(got), 32'(want));
    end
    ntbl = 0;
  endtask

  task automatic do_line(input int ny, input int sx, input int sy, input logic en);
    sif.next_y_i     = 10'(ny);
    sif.sprite_x_i   = 10'(sx);
    sif.sprite_y_i   = 10'(sy);
    sif.sprite_en_i  = en;
    sif.line_start_i = 1'b1;
    step();
    sif.line_start_i = 1'b0;
  endtask

  // Called one cycle after line_start: walks the 16 fetch cycles with draw_x parked inside the sprite.
  task automatic fetch_check(input logic [3:0] row, input int park_x, input string name);
    sif.draw_x_i = 10'(park_x);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("%s addr c%0d", name, i), 32'(sif.rom_addr_o), 32'({row, 4'(i)}));
      chk($sformatf("%s busy c%0d", name, i), 32'(sif.busy_o), 32'd1);
      if (i >= 1) chk($sformatf("%s pv c%0d", name, i), 32'(sif.pixel_valid_o), 32'd0);
      step();
    end
    chk({name, " busy end"}, 32'(sif.busy_o), 32'd0);
    chk({name, " addr end"}, 32'(sif.rom_addr_o), 32'd0);
    chk({name, " pv end"}, 32'(sif.pixel_valid_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst              = 1'b1;
    sif.line_start_i = 1'b0;
    sif.next_y_i     = '0;
    sif.sprite_x_i   = '0;
    sif.sprite_y_i   = '0;
    sif.sprite_en_i  = 1'b0;
    sif.flash_i      = 1'b0;
    sif.draw_x_i     = '0;
    #12;
    chk("reset busy", 32'(sif.busy_o), 32'd0);
    chk("reset addr", 32'(sif.rom_addr_o), 32'd0);
    chk("reset pv", 32'(sif.pixel_valid_o), 32'd0);
    chk("reset idx", 32'(sif.pixel_idx_o), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Reset landing in the middle of a fetch.
    do_line(103, 200, 100, 1'b1);
    for (int i = 0; i < 7; i++) step();
    chk("midreset addr before", 32'(sif.rom_addr_o), 32'h37);
    rst = 1'b1;
    #1;
    chk("midreset busy async", 32'(sif.busy_o), 32'd0);
    chk("midreset addr async", 32'(sif.rom_addr_o), 32'd0);
    step();
    chk("midreset busy", 32'(sif.busy_o), 32'd0);
    chk("midreset addr", 32'(sif.rom_addr_o), 32'd0);
    chk("midreset pv", 32'(sif.pixel_valid_o), 32'd0);
    rst = 1'b0;
    step();
    for (int x = 198; x < 218; x++) add_vec(x, 1'b0, 5'd0);
    run_vecs("after reset");

    // Main fetch: row 3 at x=200.
    do_line(103, 200, 100, 1'b1);
    fetch_check(4'd3, 205, "fetch r3");
    for (int x = 198; x < 218; x++) add_vec(x, 1'b0, model_px(4'd3, x, 200, 1'b0));
    add_vec(205, 1'b0, {1'b1, 4'd2});
    add_vec(202, 1'b0, {1'b1, 4'd3});
    add_vec(200, 1'b0, 5'd0);
    run_vecs("r3 noflash");
    for (int x = 198; x < 218; x++) add_vec(x, 1'b1, model_px(4'd3, x, 200, 1'b1));
    add_vec(205, 1'b1, {1'b1, 4'd0});
    add_vec(203, 1'b1, {1'b1, 4'd2});
    add_vec(204, 1'b1, 5'd0);
    add_vec(205, 1'b0, {1'b1, 4'd2});
    add_vec(205, 1'b1, {1'b1, 4'd0});
    run_vecs("r3 flash");

    // Misses: above, below, disabled. Each must also clear the previous row.
    do_line(99, 200, 100, 1'b1);
    chk("miss above busy", 32'(sif.busy_o), 32'd0);
    for (int x = 196; x < 220; x += 2) add_vec(x, 1'b0, 5'd0);
    run_vecs("miss above");
    do_line(103, 200, 100, 1'b1);
    fetch_check(4'd3, 205, "refetch r3");
    do_line(116, 200, 100, 1'b1);
    chk("miss below busy", 32'(sif.busy_o), 32'd0);
    step();
    chk("miss below busy2", 32'(sif.busy_o), 32'd0);
    for (int x = 196; x < 220; x += 2) add_vec(x, 1'b0, 5'd0);
    run_vecs("miss below");
    do_line(103, 200, 100, 1'b0);
    chk("disabled busy", 32'(sif.busy_o), 32'd0);
    chk("disabled addr", 32'(sif.rom_addr_o), 32'd0);
    for (int x = 196; x < 220; x += 2) add_vec(x, 1'b0, 5'd0);
    run_vecs("disabled");

    // Right-edge sprite must not wrap onto the left columns.
    do_line(103, 1015, 100, 1'b1);
    fetch_check(4'd3, 1018, "fetch edge");
    for (int x = 1015; x < 1024; x++) add_vec(x, 1'b0, model_px(4'd3, x, 1015, 1'b0));
    for (int x = 0; x < 7; x++) add_vec(x, 1'b0, 5'd0);
    run_vecs("edge");

    // Abort at col 5 with a new row: restart must fetch row 9 only.
    do_line(103, 200, 100, 1'b1);
    for (int i = 0; i < 5; i++) step();
    chk("abort addr before", 32'(sif.rom_addr_o), 32'h35);
    do_line(109, 200, 100, 1'b1);
    fetch_check(4'd9, 205, "abort r9");
    for (int x = 198; x < 218; x++) add_vec(x, 1'b0, model_px(4'd9, x, 200, 1'b0));
    for (int x = 200; x < 216; x += 3) add_vec(x, 1'b1, model_px(4'd9, x, 200, 1'b1));
    run_vecs("abort r9");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
